// File: rtl/io_responder_pkg.sv
// Shared constants, state encoding and byte helpers for the io_responder block.
package io_responder_pkg;

    localparam int LEN_WORD = 32;
    localparam int LEN_BYTE = 8;

    typedef enum logic [1:0] {
        IO_IDLE  = 2'd0,
        IO_WRITE = 2'd1,
        IO_READ  = 2'd2,
        IO_DONE  = 2'd3
    } io_state_e;

    // Request size is (byte count - 1); size 2 (three bytes) is a legal request.
    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd3;

    function automatic logic [LEN_BYTE-1:0] byte_of(input logic [LEN_WORD-1:0] word,
                                                    input logic [1:0] idx);
        return word[int'(idx)*LEN_BYTE +: LEN_BYTE];
    endfunction

endpackage

// File: rtl/io_responder_byte_fifo.sv
// Synchronous byte FIFO with occupancy count; a pop on an empty FIFO is ignored.
module io_byte_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO still lands when the same cycle frees a slot.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/io_responder.sv
// Device end of the core IO port: serialises writes onto the TX byte stream and
// assembles reads from the buffered RX bytes, pulsing io_received on completion.
module io_responder
    import io_responder_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   size,
    input  logic [LEN_WORD-1:0]          io_i_data,
    output logic [LEN_WORD-1:0]          io_o_data,
    input  logic                         io_write_flag,
    input  logic                         io_read_flag,
    output logic                         io_received,
    output logic [LEN_BYTE-1:0]          tx_data,
    output logic                         tx_valid,
    input  logic                         tx_ready,
    input  logic [LEN_BYTE-1:0]          rx_data,
    input  logic                         rx_valid,
    output logic                         rx_overflow,
    output logic [$clog2(FIFO_DEPTH):0]  rx_count,
    output logic [1:0]                   dbg_state_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    io_state_e            state_q;
    logic [1:0]           size_q;
    logic [1:0]           k_q;
    logic [LEN_WORD-1:0]  wdata_q;
    logic [LEN_WORD-1:0]  asm_q;
    logic [LEN_WORD-1:0]  rdata_q;
    logic [LEN_BYTE-1:0]  tx_data_q;
    logic                 tx_valid_q;
    logic                 received_q;
    logic                 overflow_q;

    logic [LEN_WORD-1:0]  asm_d;
    logic                 last_byte;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [LEN_BYTE-1:0]  fifo_dout;
    logic [CW-1:0]        fifo_count;

    io_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (LEN_BYTE)
    ) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (rx_valid),
        .data_i  (rx_data),
        .pop_i   (fifo_pop),
        .data_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign fifo_pop  = (state_q == IO_READ) && !fifo_empty;
    assign last_byte = (k_q == size_q);

    always_comb begin
        asm_d = asm_q;
        asm_d[int'(k_q)*LEN_BYTE +: LEN_BYTE] = fifo_dout;
    end

    // TX handshake: a byte transfers on a rising edge where tx_valid && tx_ready;
    // while tx_valid is high and tx_ready low, tx_data is held unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IO_IDLE;
            size_q     <= '0;
            k_q        <= '0;
            wdata_q    <= '0;
            asm_q      <= '0;
            rdata_q    <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            received_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            case (state_q)
                IO_IDLE: begin
                    if (io_write_flag) begin
                        wdata_q    <= io_i_data;
                        size_q     <= size;
                        k_q        <= '0;
                        tx_data_q  <= byte_of(io_i_data, 2'd0);
                        tx_valid_q <= 1'b1;
                        state_q    <= IO_WRITE;
                    end else if (io_read_flag) begin
                        size_q  <= size;
                        asm_q   <= '0;
                        k_q     <= '0;
                        state_q <= IO_READ;
                    end
                end
                IO_WRITE: begin
                    if (tx_ready) begin
                        if (last_byte) begin
                            tx_valid_q <= 1'b0;
                            tx_data_q  <= '0;
                            rdata_q    <= '0;
                            received_q <= 1'b1;
                            state_q    <= IO_DONE;
                        end else begin
                            k_q       <= k_q + 2'd1;
                            tx_data_q <= byte_of(wdata_q, k_q + 2'd1);
                        end
                    end
                end
                IO_READ: begin
                    if (!fifo_empty) begin
                        asm_q <= asm_d;
                        if (last_byte) begin
                            rdata_q    <= asm_d;
                            received_q <= 1'b1;
                            state_q    <= IO_DONE;
                        end else begin
                            k_q <= k_q + 2'd1;
                        end
                    end
                end
                IO_DONE: begin
                    received_q <= 1'b0;
                    state_q    <= IO_IDLE;
                end
                default: begin
                    state_q <= IO_IDLE;
                end
            endcase

            // Sticky: a byte arrived with no room and no pop freeing a slot.
            if (rx_valid && fifo_full && !fifo_pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign io_o_data   = rdata_q;
    assign io_received = received_q;
    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign rx_overflow = overflow_q;
    assign rx_count    = fifo_count;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_io_responder.sv
// Directed bench for io_responder: write serialisation, read assembly, FIFO edges, reset abort.
module tb_io_responder;

    localparam logic [31:0] ST_IDLE  = 32'd0;
    localparam logic [31:0] ST_WRITE = 32'd1;
    localparam logic [31:0] ST_READ  = 32'd2;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  size;
    logic [31:0] io_i_data;
    logic [31:0] io_o_data;
    logic        io_write_flag;
    logic        io_read_flag;
    logic        io_received;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_overflow;
    logic [4:0]  rx_count;
    logic [1:0]  dbg_state_o;

    int n_vec  = 0;
    int n_miss = 0;
    int rcv_cnt = 0;
    int rcv_base;
    logic [7:0] exp_q[$];

    io_responder #(.FIFO_DEPTH(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .size          (size),
        .io_i_data     (io_i_data),
        .io_o_data     (io_o_data),
        .io_write_flag (io_write_flag),
        .io_read_flag  (io_read_flag),
        .io_received   (io_received),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_overflow   (rx_overflow),
        .rx_count      (rx_count),
        .dbg_state_o   (dbg_state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change only 2 time units after a rising edge; outputs are sampled on falling edges.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_rcv(input string tag, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (io_received !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_received"}, {31'd0, io_received}, 32'd1);
    endtask

    // TX scoreboard: every transferred byte must be the next expected one.
    always @(negedge clk) begin
        if (rst === 1'b0 && tx_valid === 1'b1 && tx_ready === 1'b1) begin
            check("tx_byte_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                check("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (io_received === 1'b1) rcv_cnt++;
    end

    logic [31:0] word_exp [3];
    int          cnt_exp  [3];

    initial begin
        rst = 1'b1;
        size = 2'd0;
        io_i_data = '0;
        io_write_flag = 1'b0;
        io_read_flag = 1'b0;
        tx_ready = 1'b0;
        rx_data = '0;
        rx_valid = 1'b0;

        // Reset state
        step(2);
        @(negedge clk);
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_received", {31'd0, io_received}, 32'd0);
        check("rst_o_data", io_o_data, 32'd0);
        check("rst_count", {27'd0, rx_count}, 32'd0);
        check("rst_state", {30'd0, dbg_state_o}, ST_IDLE);
        step(1);
        rst = 1'b0;
        step(1);

        // Word write, tx_ready high: EF BE AD DE then io_received
        size = 2'd3;
        io_i_data = 32'hDEADBEEF;
        io_write_flag = 1'b1;
        tx_ready = 1'b1;
        exp_q.push_back(8'hEF); exp_q.push_back(8'hBE);
        exp_q.push_back(8'hAD); exp_q.push_back(8'hDE);
        step(1);
        io_write_flag = 1'b0;
        begin
            logic [31:0] w;
            w = 32'hDEADBEEF;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                check("ww_valid", {31'd0, tx_valid}, 32'd1);
                check("ww_data", {24'd0, tx_data}, {24'd0, w[8*i +: 8]});
                check("ww_no_rcv", {31'd0, io_received}, 32'd0);
            end
        end
        @(negedge clk);
        check("ww_rcv", {31'd0, io_received}, 32'd1);
        check("ww_tx_idle", {31'd0, tx_valid}, 32'd0);
        check("ww_o_data", io_o_data, 32'd0);
        step(1);
        @(negedge clk);
        check("ww_rcv_pulse", {31'd0, io_received}, 32'd0);
        check("ww_state_idle", {30'd0, dbg_state_o}, ST_IDLE);

        // Byte read of a preloaded 0x41
        step(1);
        rx_data = 8'h41;
        rx_valid = 1'b1;
        step(1);
        rx_valid = 1'b0;
        @(negedge clk);
        check("br_count1", {27'd0, rx_count}, 32'd1);
        size = 2'd0;
        io_read_flag = 1'b1;
        step(1);
        io_read_flag = 1'b0;
        @(negedge clk);
        check("br_state", {30'd0, dbg_state_o}, ST_READ);
        @(negedge clk);
        check("br_rcv", {31'd0, io_received}, 32'd1);
        check("br_data", io_o_data, 32'h00000041);
        check("br_count0", {27'd0, rx_count}, 32'd0);
        step(1);

        // Halfword read on empty FIFO, bytes arrive 5 cycles apart
        size = 2'd1;
        io_read_flag = 1'b1;
        step(1);
        io_read_flag = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("hw_wait_state", {30'd0, dbg_state_o}, ST_READ);
            check("hw_wait_rcv", {31'd0, io_received}, 32'd0);
        end
        step(1);
        rx_data = 8'h34;
        rx_valid = 1'b1;
        step(1);
        rx_valid = 1'b0;
        @(negedge clk);
        check("hw_count1", {27'd0, rx_count}, 32'd1);
        @(negedge clk);
        check("hw_count_popped", {27'd0, rx_count}, 32'd0);
        check("hw_still_read", {30'd0, dbg_state_o}, ST_READ);
        step(3);
        rx_data = 8'h12;
        rx_valid = 1'b1;
        step(1);
        rx_valid = 1'b0;
        @(negedge clk);
        check("hw_pre_pop_rcv", {31'd0, io_received}, 32'd0);
        check("hw_pre_pop_count", {27'd0, rx_count}, 32'd1);
        @(negedge clk);
        check("hw_rcv", {31'd0, io_received}, 32'd1);
        check("hw_data", io_o_data, 32'h00001234);
        check("hw_count0", {27'd0, rx_count}, 32'd0);
        step(1);

        // TX backpressure: three stalled cycles hold 0xCD
        tx_ready = 1'b0;
        size = 2'd1;
        io_i_data = 32'h0000ABCD;
        io_write_flag = 1'b1;
        exp_q.push_back(8'hCD); exp_q.push_back(8'hAB);
        rcv_base = rcv_cnt;
        step(1);
        io_write_flag = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_stall_valid", {31'd0, tx_valid}, 32'd1);
            check("bp_stall_data", {24'd0, tx_data}, 32'h000000CD);
            step(1);
        end
        tx_ready = 1'b1;
        @(negedge clk);
        check("bp_byte0", {24'd0, tx_data}, 32'h000000CD);
        @(negedge clk);
        check("bp_byte1", {24'd0, tx_data}, 32'h000000AB);
        check("bp_no_rcv", {31'd0, io_received}, 32'd0);
        @(negedge clk);
        check("bp_rcv", {31'd0, io_received}, 32'd1);
        check("bp_o_data_zero", io_o_data, 32'd0);
        step(3);
        check("bp_one_rcv", rcv_cnt - rcv_base, 32'd1);

        // Overflow: 16 fill the FIFO, the 17th is dropped
        for (int i = 0; i < 16; i++) begin
            rx_data = 8'(i);
            rx_valid = 1'b1;
            step(1);
        end
        rx_valid = 1'b0;
        @(negedge clk);
        check("of_count_full", {27'd0, rx_count}, 32'd16);
        check("of_no_ovf_yet", {31'd0, rx_overflow}, 32'd0);
        rx_data = 8'h10;
        rx_valid = 1'b1;
        step(1);
        rx_valid = 1'b0;
        @(negedge clk);
        check("of_count_held", {27'd0, rx_count}, 32'd16);
        check("of_ovf", {31'd0, rx_overflow}, 32'd1);

        // First word read pushes 0x55 on the full-FIFO pop edge
        step(1);
        size = 2'd3;
        io_read_flag = 1'b1;
        step(1);
        io_read_flag = 1'b0;
        rx_data = 8'h55;
        rx_valid = 1'b1;
        step(1);
        rx_valid = 1'b0;
        @(negedge clk);
        check("of_push_pop_full", {27'd0, rx_count}, 32'd16);
        wait_rcv("wr0", 20);
        check("wr0_data", io_o_data, 32'h03020100);
        check("wr0_count", {27'd0, rx_count}, 32'd13);
        step(1);

        word_exp[0] = 32'h07060504; cnt_exp[0] = 9;
        word_exp[1] = 32'h0B0A0908; cnt_exp[1] = 5;
        word_exp[2] = 32'h0F0E0D0C; cnt_exp[2] = 1;
        for (int r = 0; r < 3; r++) begin
            size = 2'd3;
            io_read_flag = 1'b1;
            step(1);
            io_read_flag = 1'b0;
            wait_rcv("wr", 20);
            check("wr_data", io_o_data, word_exp[r]);
            check("wr_count", {27'd0, rx_count}, cnt_exp[r]);
            step(1);
        end

        size = 2'd0;
        io_read_flag = 1'b1;
        step(1);
        io_read_flag = 1'b0;
        wait_rcv("br55", 20);
        check("br55_data", io_o_data, 32'h00000055);
        check("br55_count", {27'd0, rx_count}, 32'd0);
        check("of_sticky", {31'd0, rx_overflow}, 32'd1);
        step(1);

        // Both flags high: write wins even with an empty FIFO
        size = 2'd0;
        io_i_data = 32'h00000077;
        io_write_flag = 1'b1;
        io_read_flag = 1'b1;
        exp_q.push_back(8'h77);
        step(1);
        io_write_flag = 1'b0;
        io_read_flag = 1'b0;
        @(negedge clk);
        check("prio_state", {30'd0, dbg_state_o}, ST_WRITE);
        check("prio_data", {24'd0, tx_data}, 32'h00000077);
        @(negedge clk);
        check("prio_rcv", {31'd0, io_received}, 32'd1);
        step(1);

        // Reset after two bytes of a word write
        rx_data = 8'hA5;
        rx_valid = 1'b1;
        step(2);
        rx_valid = 1'b0;
        size = 2'd3;
        io_i_data = 32'h11223344;
        io_write_flag = 1'b1;
        exp_q.push_back(8'h44); exp_q.push_back(8'h33);
        rcv_base = rcv_cnt;
        step(1);
        io_write_flag = 1'b0;
        step(2);
        rst = 1'b1;
        @(negedge clk);
        check("ra_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("ra_rcv", {31'd0, io_received}, 32'd0);
        check("ra_state", {30'd0, dbg_state_o}, ST_IDLE);
        check("ra_count", {27'd0, rx_count}, 32'd0);
        check("ra_ovf", {31'd0, rx_overflow}, 32'd0);
        step(2);
        rst = 1'b0;
        step(4);
        check("ra_no_rcv_after", rcv_cnt - rcv_base, 32'd0);
        @(negedge clk);
        check("ra_tx_quiet", {31'd0, tx_valid}, 32'd0);
        check("ra_idle_after", {30'd0, dbg_state_o}, ST_IDLE);
        check("tx_queue_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
